// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

   // Fetch sequencer states: issue request, await response, present to decode,
   // swallow the response of a squashed fetch.
   typedef enum logic [1:0] {
      StReq,
      StWait,
      StHold,
      StDrop
   } fetch_state_e;

   localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
   localparam logic [31:0] DefaultPcInc   = 32'd4;
   localparam logic [31:0] PcAlignMask    = 32'hFFFF_FFFC;

   // Force a fetch address onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & PcAlignMask;
   endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: async reset, load (redirect) beats increment.
module fetch_pc_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DefaultResetPc,
   parameter logic [31:0] PC_INC   = DefaultPcInc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_en,
   input  logic [31:0] load_value,
   input  logic        inc_en,
   output logic [31:0] pc
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Next PC: load wins over increment; increment wraps modulo 2^32.
   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = load_value;
      end else if (inc_en) begin
         pc_d = pc_q + PC_INC;
      end
   end

   // PC state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, one-entry holding register
// to decode, redirects squash any in-flight or held instruction.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DefaultResetPc,
   parameter logic [31:0] PC_INC   = DefaultPcInc
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic [31:0] pc_out
);

   fetch_state_e state_q, state_d;
   logic         inst_valid_q, inst_valid_d;
   logic [31:0]  inst_data_q, inst_data_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         pc_inc;
   logic [31:0]  pc;

   fetch_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_INC   (PC_INC)
   ) u_pc_reg (
      .clk        (clk),
      .reset      (reset),
      .load_en    (redirect_valid),
      .load_value (align_pc(redirect_target)),
      .inc_en     (pc_inc),
      .pc         (pc)
   );

   // Next-state and holding-register update; redirect outranks normal progress.
   always_comb begin
      state_d      = state_q;
      inst_valid_d = inst_valid_q;
      inst_data_d  = inst_data_q;
      inst_pc_d    = inst_pc_q;
      pc_inc       = 1'b0;
      unique case (state_q)
         StReq: begin
            // imem_req_valid is high here, so ready alone completes the handshake.
            if (imem_req_ready) begin
               if (redirect_valid) begin
                  state_d = StDrop;
               end else begin
                  state_d   = StWait;
                  inst_pc_d = pc;
               end
            end
         end
         StWait: begin
            if (redirect_valid) begin
               state_d = imem_resp_valid ? StReq : StDrop;
            end else if (imem_resp_valid) begin
               state_d      = StHold;
               inst_valid_d = 1'b1;
               inst_data_d  = imem_resp_data;
               pc_inc       = 1'b1;
            end
         end
         StHold: begin
            if (redirect_valid || inst_ready) begin
               state_d      = StReq;
               inst_valid_d = 1'b0;
            end
         end
         StDrop: begin
            if (imem_resp_valid) begin
               state_d = StReq;
            end
         end
         default: begin
            state_d = StReq;
         end
      endcase
   end

   // FSM and holding-register state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StReq;
         inst_valid_q <= 1'b0;
         inst_data_q  <= 32'h0;
         inst_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         inst_valid_q <= inst_valid_d;
         inst_data_q  <= inst_data_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   assign imem_req_valid = (state_q == StReq) && !reset;
   assign imem_req_addr  = pc;
   assign pc_out         = pc;
   assign inst_valid     = inst_valid_q;
   assign inst_data      = inst_data_q;
   assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; a second instance with a top-of-memory reset
// PC shares all inputs and is checked for address wrap.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        imem_req_ready = 1'b0;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        inst_ready = 1'b0;

   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst_data, inst_pc, pc_out;
   logic        w_req_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_inst_data, w_inst_pc, w_pc_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_ctrl u_dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst_data       (inst_data),
      .inst_pc         (inst_pc),
      .inst_ready      (inst_ready),
      .pc_out          (pc_out)
   );

   fetch_ctrl #(
      .RESET_PC (32'hFFFF_FFFC)
   ) u_wrap (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req_valid  (w_req_valid),
      .imem_req_addr   (w_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (w_inst_valid),
      .inst_data       (w_inst_data),
      .inst_pc         (w_inst_pc),
      .inst_ready      (inst_ready),
      .pc_out          (w_pc_out)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (imem_req_valid !== 1'b0) begin
         errors++; $display("FAIL rst_req_valid got %0b want 0", imem_req_valid);
      end
      checks++;
      if (pc_out !== 32'h0) begin
         errors++; $display("FAIL rst_pc got %08h want 00000000", pc_out);
      end
      checks++;
      if (w_pc_out !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL rst_wrap_pc got %08h want fffffffc", w_pc_out);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL rst_first_req got v=%0b a=%08h want v=1 a=00000000",
                  imem_req_valid, imem_req_addr);
      end
      checks++;
      if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
         errors++;
         $display("FAIL rst_hold got v=%0b d=%08h pc=%08h want 0/0/0",
                  inst_valid, inst_data, inst_pc);
      end
   endtask

   // Three sequential fetches, 1-cycle memory, decode always ready.
   task automatic test_seq();
      logic [31:0] addr;
      for (int i = 0; i < 3; i++) begin
         addr = 32'(i * 4);
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== addr) begin
            errors++;
            $display("FAIL seq_req[%0d] got v=%0b a=%08h want v=1 a=%08h",
                     i, imem_req_valid, imem_req_addr, addr);
         end
         imem_req_ready = 1'b1;
         tick();
         imem_req_ready = 1'b0;
         checks++;
         if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_wait[%0d] got req=%0b iv=%0b want 0/0",
                     i, imem_req_valid, inst_valid);
         end
         imem_resp_valid = 1'b1;
         imem_resp_data  = addr ^ 32'hA5A5_0000;
         tick();
         imem_resp_valid = 1'b0;
         checks++;
         if (inst_valid !== 1'b1 || inst_data !== (addr ^ 32'hA5A5_0000) ||
             inst_pc !== addr || pc_out !== addr + 32'd4) begin
            errors++;
            $display("FAIL seq_inst[%0d] got v=%0b d=%08h pc=%08h fpc=%08h want 1/%08h/%08h/%08h",
                     i, inst_valid, inst_data, inst_pc, pc_out,
                     addr ^ 32'hA5A5_0000, addr, addr + 32'd4);
         end
         if (i == 0) begin
            checks++;
            if (w_pc_out !== 32'h0 || w_inst_pc !== 32'hFFFF_FFFC) begin
               errors++;
               $display("FAIL wrap_pc got pc=%08h ipc=%08h want 00000000/fffffffc",
                        w_pc_out, w_inst_pc);
            end
         end
         inst_ready = 1'b1;
         tick();
         inst_ready = 1'b0;
         checks++;
         if (inst_valid !== 1'b0) begin
            errors++; $display("FAIL seq_consume[%0d] got %0b want 0", i, inst_valid);
         end
      end
   endtask

   // Decode stalls for 5 cycles with an instruction held.
   task automatic test_hold();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1234_5678;
      tick();
      imem_resp_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (inst_valid !== 1'b1 || inst_data !== 32'h1234_5678 || inst_pc !== 32'hC ||
             imem_req_valid !== 1'b0 || pc_out !== 32'h10) begin
            errors++;
            $display("FAIL hold[%0d] got v=%0b d=%08h pc=%08h req=%0b fpc=%08h want 1/12345678/0000000c/0/00000010",
                     i, inst_valid, inst_data, inst_pc, imem_req_valid, pc_out);
         end
         tick();
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
         errors++;
         $display("FAIL hold_release got iv=%0b req=%0b a=%08h want 0/1/00000010",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   // Redirect while waiting; the late response must be swallowed.
   task automatic test_redirect_wait();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_1003;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || pc_out !== 32'h1000) begin
            errors++;
            $display("FAIL drop_wait[%0d] got req=%0b iv=%0b pc=%08h want 0/0/00001000",
                     i, imem_req_valid, inst_valid, pc_out);
         end
         tick();
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h1000) begin
         errors++;
         $display("FAIL drop_exit got iv=%0b req=%0b a=%08h want 0/1/00001000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   // Redirect coincident with the response in WAIT.
   task automatic test_redirect_resp();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0001;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0200;
      tick();
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
         errors++;
         $display("FAIL redir_resp got iv=%0b req=%0b a=%08h want 0/1/00000200",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   // Redirect in REQ (with and without handshake) and in the first HOLD cycle.
   task automatic test_redirect_req();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0340;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h340) begin
         errors++;
         $display("FAIL redir_req got v=%0b a=%08h want 1/00000340", imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0 || inst_pc !== 32'h340) begin
         errors++;
         $display("FAIL redir_accept got req=%0b ipc=%08h want 0/00000340", imem_req_valid, inst_pc);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0BAD_F00D;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h340 || inst_data !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL redir_fetch got v=%0b pc=%08h d=%08h want 1/00000340/0badf00d",
                  inst_valid, inst_pc, inst_data);
      end
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0500;
      tick();
      redirect_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin
         errors++;
         $display("FAIL redir_hold got iv=%0b req=%0b a=%08h want 0/1/00000500",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      // Redirect on the handshake cycle: request goes out, its response is dropped.
      imem_req_ready  = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0600;
      tick();
      imem_req_ready = 1'b0;
      redirect_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b0 || pc_out !== 32'h600) begin
         errors++;
         $display("FAIL redir_hs got req=%0b pc=%08h want 0/00000600", imem_req_valid, pc_out);
      end
      imem_resp_valid = 1'b1;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h600) begin
         errors++;
         $display("FAIL redir_hs_drop got iv=%0b req=%0b a=%08h want 0/1/00000600",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
   endtask

   // Async reset mid-WAIT, then a stale response after release.
   task automatic test_reset_wait();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if (pc_out !== 32'h0 || inst_valid !== 1'b0 || inst_pc !== 32'h0 ||
          imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstw_async got pc=%08h iv=%0b ipc=%08h req=%0b want 0/0/0/0",
                  pc_out, inst_valid, inst_pc, imem_req_valid);
      end
      tick();
      reset = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h5A5A_5A5A;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL rstw_stale got iv=%0b req=%0b a=%08h want 0/1/00000000",
                  inst_valid, imem_req_valid, imem_req_addr);
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h0000_0013;
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h13 ||
          pc_out !== 32'h4) begin
         errors++;
         $display("FAIL rstw_refetch got v=%0b pc=%08h d=%08h fpc=%08h want 1/0/00000013/00000004",
                  inst_valid, inst_pc, inst_data, pc_out);
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_seq();
      test_hold();
      test_redirect_wait();
      test_redirect_resp();
      test_redirect_req();
      test_reset_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer for the single-cycle core's front end. Owns the fetch PC and issues one instruction-memory request at a time over a valid/ready handshake. Captures the response into a one-entry holding register presented to decode. Applies branch/jump redirects, squashing any in-flight or held instruction; it replaces a free-running PC with a stall- and redirect-aware one.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset (bits [1:0] must be 0)
PC_INC, 4, byte increment between sequential instructions

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  32  new fetch address; bits [1:0] ignored (forced 0)
imem_req_valid  output  1  request to instruction memory
imem_req_addr  output  32  request address (= pc_out)
imem_req_ready  input  1  memory accepts request this cycle
imem_resp_valid  input  1  response data valid (exactly one per accepted request, ≥1 cycle later)
imem_resp_data  input  32  instruction word
inst_valid  output  1  held instruction valid to decode
inst_data  output  32  held instruction word
inst_pc  output  32  address of held instruction
inst_ready  input  1  decode consumes held instruction
pc_out  output  32  current fetch PC

Behaviour:
- Reset (async, any state, mid-transaction included): pc=RESET_PC, state=REQ, inst_valid=0, inst_data=0, inst_pc=0. imem_req_valid is forced 0 while reset is high. A response arriving after reset deassertion with no request accepted since reset is ignored.
- States: REQ, WAIT, HOLD, DROP. imem_req_valid = (state==REQ) && !reset. imem_req_addr = pc_out = pc.
- Priority per cycle: reset > redirect > normal progress.
- REQ:
  - Handshake (req_valid & req_ready), no redirect -> WAIT; inst_pc<=pc.
  - Redirect without handshake -> pc<=target, stay REQ.
  - Redirect with handshake -> pc<=target, DROP.
- WAIT:
  - resp_valid, no redirect -> inst_data<=resp_data, inst_valid<=1, pc<=pc+PC_INC (mod 2^32, wraps FFFF_FFFC->0), HOLD.
  - Redirect -> pc<=target; if resp_valid same cycle, discard and go REQ, else go DROP.
- HOLD:
  - inst_valid=1, all held fields stable until consumed.
  - inst_ready -> inst_valid<=0, REQ.
  - Redirect (with or without inst_ready) -> inst_valid<=0, pc<=target, REQ. The held instruction counts as consumed if inst_ready was 1, squashed otherwise.
- DROP:
  - resp_valid -> discard, REQ.
  - Redirect -> pc<=target; leave DROP only when the response arrives.
- Single outstanding request. inst_valid never asserts for a squashed fetch.
- Latency: request accepted at cycle t, response at t+k (k≥1), inst_valid at t+k+1. Best-case throughput is 1 instruction per 3 cycles.
- Redirect in the cycle inst_valid first rises is allowed and squashes it next cycle.

Decomposition:
- fetch_pkg holds:
  - the state enum (REQ, WAIT, HOLD, DROP)
  - default RESET_PC
  - PC_INC
  - an alignment mask constant 32'hFFFF_FFFC
- Sub-module fetch_pc_reg: the 32-bit PC register with async reset to RESET_PC, load (redirect) and increment enables; load has priority over increment.
- The FSM and holding register live in fetch_ctrl.

Test Plan:
- Reset then memory with ready=1 and 1-cycle response returning addr^32'hA5A5_0000, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8, each inst_valid 3 cycles apart, data matches.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst_valid/inst_data/inst_pc stable, imem_req_valid=0, pc_out=inst_pc+4.
- Redirect to 0x0000_1003 in WAIT, response 3 cycles later -> state DROP, response discarded, next request addr=0x0000_1000, no inst_valid for the old fetch.
- Redirect to 0x200 in the same cycle as resp_valid in WAIT -> response discarded, next cycle imem_req_valid=1 with addr 0x200.
- Redirect while REQ with req_ready=0, then req_ready=1 -> first accepted address equals the redirect target.
- Start with RESET_PC=32'hFFFF_FFFC -> after one fetch pc_out=0x0. Assert reset during WAIT -> pc=RESET_PC, inst_valid=0 immediately, stale response ignored.
